// File: rtl/tcp_test_gen_mc.sv
// Multi-channel counter-pattern generator for the SiTCPXG TX interface.
// Round-robin framed blocks with a fractional rate throttle, AFULL stall and one-shot error insertion.

module tcp_test_gen_mc #(
    parameter int NCH   = 4,
    parameter int CNT_W = 32,
    parameter int BLK_W = 16
) (
    input  logic             CLK156M,
    input  logic             RSTs_N,
    input  logic             SiTCPXG_ESTABLISHED,
    input  logic             DATA_GEN,
    input  logic [NCH-1:0]   CH_ENB,
    input  logic [7:0]       TX_RATE,
    input  logic [CNT_W-1:0] NUM_OF_WORDS,
    input  logic [BLK_W-1:0] BLK_WORDS,
    input  logic             INS_ERROR,
    input  logic             SiTCPXG_TX_AFULL,
    output logic [63:0]      SiTCPXG_TX_D,
    output logic [3:0]       SiTCPXG_TX_B,
    output logic             BUSY,
    output logic             DONE,
    output logic [NCH-1:0]   CH_DONE
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LEN_W = (CNT_W > BLK_W) ? CNT_W : BLK_W;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_HDR, S_PAY} state_t;

    state_t           state_q, state_d;
    logic             dgen_q, dgen_d;
    logic             stop_q, stop_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]       acc_q, acc_d;
    logic             token_q, token_d;
    logic             err_q, err_d;
    logic [63:0]      txd_q, txd_d;
    logic [3:0]       txb_q, txb_d;
    logic             done_q, done_d;
    logic [NCH-1:0]   chdone_q, chdone_d;

    logic [CNT_W-1:0] rem_q  [NCH];
    logic [CNT_W-1:0] rem_d  [NCH];
    logic [15:0]      seq_q  [NCH];
    logic [15:0]      seq_d  [NCH];
    logic [55:0]      wcnt_q [NCH];
    logic [55:0]      wcnt_d [NCH];

    logic             busy;
    logic             start;
    logic             fall;
    logic             emit;
    logic [8:0]       sum;
    logic             found;
    logic [CH_W-1:0]  pick;
    logic [LEN_W-1:0] rem_ext;
    logic [LEN_W-1:0] blk_ext;

    assign busy  = (state_q != S_IDLE);
    assign start = DATA_GEN & ~dgen_q & SiTCPXG_ESTABLISHED & ~busy;
    assign fall  = ~DATA_GEN & dgen_q;
    assign sum   = {1'b0, acc_q} + {1'b0, TX_RATE} + 9'd1;
    assign emit  = token_q & ~SiTCPXG_TX_AFULL & SiTCPXG_ESTABLISHED
                 & ((state_q == S_HDR) | (state_q == S_PAY));

    // Next grant: first channel after the RR pointer (wrapping) with words left.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int i = 1; i <= NCH; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NCH;
            if (!found && rem_q[CH_W'(idx)] != '0) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
        rem_ext = LEN_W'(rem_q[pick]);
        blk_ext = LEN_W'(blk_q);
    end

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        dgen_d   = DATA_GEN;
        stop_d   = stop_q;
        blk_d    = blk_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        len_d    = len_q;
        pcnt_d   = pcnt_q;
        acc_d    = acc_q;
        token_d  = (token_q & ~emit) | (busy & sum[8]);
        err_d    = INS_ERROR | (err_q & ~(emit & (state_q == S_PAY)));
        txd_d    = txd_q;
        txb_d    = 4'd0;
        done_d   = 1'b0;
        chdone_d = chdone_q;
        rem_d    = rem_q;
        seq_d    = seq_q;
        wcnt_d   = wcnt_q;

        if (busy) begin
            acc_d = sum[7:0];
            if (fall) stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARB;
                    blk_d   = (BLK_WORDS == '0) ? BLK_W'(1) : BLK_WORDS;
                    stop_d  = 1'b0;
                    err_d   = 1'b0;
                    for (int c = 0; c < NCH; c++) begin
                        rem_d[c]    = CH_ENB[c] ? NUM_OF_WORDS : '0;
                        seq_d[c]    = '0;
                        wcnt_d[c]   = '0;
                        chdone_d[c] = ~CH_ENB[c] | (NUM_OF_WORDS == '0);
                    end
                end
            end
            S_ARB: begin
                if (!found) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (stop_q || fall) begin
                    state_d = S_IDLE;
                end else begin
                    rr_d    = pick;
                    grant_d = pick;
                    len_d   = (rem_ext > blk_ext) ? CNT_W'(blk_q) : rem_q[pick];
                    pcnt_d  = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (emit) begin
                    txb_d   = 4'd8;
                    txd_d   = {8'hA5, 8'(grant_q), seq_q[grant_q], 32'(len_q)};
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                if (emit) begin
                    txb_d = 4'd8;
                    txd_d = {8'(grant_q), wcnt_q[grant_q]} ^ {63'd0, err_q};
                    wcnt_d[grant_q] = wcnt_q[grant_q] + 56'd1;
                    pcnt_d = pcnt_q + CNT_W'(1);
                    if (pcnt_q == len_q - CNT_W'(1)) begin
                        rem_d[grant_q] = rem_q[grant_q] - len_q;
                        seq_d[grant_q] = seq_q[grant_q] + 16'd1;
                        if (rem_q[grant_q] == len_q) chdone_d[grant_q] = 1'b1;
                        state_d = S_ARB;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Losing the session abandons the block immediately.
        if (busy && !SiTCPXG_ESTABLISHED) state_d = S_IDLE;
    end

    always_ff @(posedge CLK156M) begin
        if (!RSTs_N) begin
            state_q  <= S_IDLE;
            dgen_q   <= 1'b0;
            stop_q   <= 1'b0;
            blk_q    <= '0;
            rr_q     <= CH_W'(NCH - 1);
            grant_q  <= '0;
            len_q    <= '0;
            pcnt_q   <= '0;
            acc_q    <= '0;
            token_q  <= 1'b0;
            err_q    <= 1'b0;
            txd_q    <= '0;
            txb_q    <= '0;
            done_q   <= 1'b0;
            chdone_q <= '0;
        end else begin
            state_q  <= state_d;
            dgen_q   <= dgen_d;
            stop_q   <= stop_d;
            blk_q    <= blk_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            len_q    <= len_d;
            pcnt_q   <= pcnt_d;
            acc_q    <= acc_d;
            token_q  <= token_d;
            err_q    <= err_d;
            txd_q    <= txd_d;
            txb_q    <= txb_d;
            done_q   <= done_d;
            chdone_q <= chdone_d;
        end
    end

    // NOTE: per-channel counters are fully rewritten on every start, so they carry no reset.
    always_ff @(posedge CLK156M) begin
        rem_q  <= rem_d;
        seq_q  <= seq_d;
        wcnt_q <= wcnt_d;
    end

    assign SiTCPXG_TX_D = txd_q;
    assign SiTCPXG_TX_B = txb_q;
    assign BUSY         = busy;
    assign DONE         = done_q;
    assign CH_DONE      = chdone_q;

endmodule

// File: tb/tb_tcp_test_gen_mc.sv
// Scoreboard bench for tcp_test_gen_mc: a transaction model queues the expected word stream per run,
// a negedge monitor pops and compares every emitted word.

module tb_tcp_test_gen_mc;

    localparam int NCH   = 4;
    localparam int CNT_W = 32;
    localparam int BLK_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             est;
    logic             dgen;
    logic [NCH-1:0]   ch_enb;
    logic [7:0]       tx_rate;
    logic [CNT_W-1:0] num_words;
    logic [BLK_W-1:0] blk_words;
    logic             ins_err;
    logic             afull;
    logic [63:0]      tx_d;
    logic [3:0]       tx_b;
    logic             busy;
    logic             done;
    logic [NCH-1:0]   ch_done;

    tcp_test_gen_mc #(.NCH(NCH), .CNT_W(CNT_W), .BLK_W(BLK_W)) dut (
        .CLK156M             (clk),
        .RSTs_N              (rst_n),
        .SiTCPXG_ESTABLISHED (est),
        .DATA_GEN            (dgen),
        .CH_ENB              (ch_enb),
        .TX_RATE             (tx_rate),
        .NUM_OF_WORDS        (num_words),
        .BLK_WORDS           (blk_words),
        .INS_ERROR           (ins_err),
        .SiTCPXG_TX_AFULL    (afull),
        .SiTCPXG_TX_D        (tx_d),
        .SiTCPXG_TX_B        (tx_b),
        .BUSY                (busy),
        .DONE                (done),
        .CH_DONE             (ch_done)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          last_cyc    = 0;
    int          n_emit      = 0;
    int          gap_bad     = 0;
    int          done_cnt    = 0;
    int          m_rr        = NCH - 1;
    logic [63:0] sb [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word stream of one run, built from the block/arbitration rules.
    task automatic push_run(input logic [NCH-1:0] enb, input int num, input int blk,
                            input bit err, input int max_blk);
        int          rem [NCH];
        int          seq [NCH];
        logic [55:0] wc  [NCH];
        int          b, p, c, len, nblk;
        bit          found, err_left;
        logic [63:0] w;
        b        = (blk == 0) ? 1 : blk;
        p        = m_rr;
        nblk     = 0;
        err_left = err;
        for (int i = 0; i < NCH; i++) begin
            rem[i] = enb[i] ? num : 0;
            seq[i] = 0;
            wc[i]  = '0;
        end
        forever begin
            found = 0;
            c     = 0;
            for (int i = 1; i <= NCH; i++) begin
                if (!found && rem[(p + i) % NCH] > 0) begin
                    found = 1;
                    c     = (p + i) % NCH;
                end
            end
            if (!found || (max_blk != 0 && nblk == max_blk)) break;
            p   = c;
            len = (rem[c] < b) ? rem[c] : b;
            sb.push_back({8'hA5, 8'(c), 16'(seq[c]), 32'(len)});
            for (int k = 0; k < len; k++) begin
                w = {8'(c), wc[c]};
                if (err_left) begin
                    w[0]     = ~w[0];
                    err_left = 0;
                end
                sb.push_back(w);
                wc[c] = wc[c] + 56'd1;
            end
            rem[c] -= len;
            seq[c]++;
            nblk++;
        end
        m_rr = p;
    endtask

    task automatic start_run(input logic [NCH-1:0] enb, input int num, input int blk, input int rate);
        ch_enb    = enb;
        num_words = CNT_W'(num);
        blk_words = BLK_W'(blk);
        tx_rate   = 8'(rate);
        dgen      = 1'b0;
        tick();
        dgen      = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        tick();
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 64'(busy), 64'd0);
        tick();
        tick();
    endtask

    task automatic wait_emit(input string tag, input int count, input int budget);
        int n = 0;
        while (n_emit < count && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_emit_reached"}, 64'(n_emit >= count), 64'd1);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_b != 4'd0) begin
                check("tx_b", 64'(tx_b), 64'd8);
                if (sb.size() == 0) begin
                    check("sb_has_word", 64'(sb.size()), 64'd1);
                end else begin
                    logic [63:0] exp_w;
                    exp_w = sb.pop_front();
                    check("tx_d", tx_d, exp_w);
                end
                if (n_emit >= 2 && (cyc - last_cyc) != 4) gap_bad++;
                last_cyc = cyc;
                n_emit++;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int viol;
        rst_n     = 1'b0;
        est       = 1'b1;
        dgen      = 1'b0;
        ch_enb    = '0;
        tx_rate   = 8'd255;
        num_words = '0;
        blk_words = '0;
        ins_err   = 1'b0;
        afull     = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx_b", 64'(tx_b), 64'd0);
        check("rst_tx_d", tx_d, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ch_done", 64'(ch_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Four channels, 10 words each in blocks of 4: 52 words in RR order.
        push_run(4'hF, 10, 4, 0, 0);
        n_emit = 0;
        d0     = done_cnt;
        start_run(4'hF, 10, 4, 255);
        wait_idle("rr", 500);
        check("rr_words", 64'(n_emit), 64'd52);
        check("rr_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("rr_ch_done", 64'(ch_done), 64'hF);
        check("rr_sb_drained", 64'(sb.size()), 64'd0);

        // Rate 63: one word every 4 cycles in steady state.
        push_run(4'h1, 100, 100, 0, 0);
        n_emit  = 0;
        gap_bad = 0;
        start_run(4'h1, 100, 100, 63);
        wait_idle("rate", 1000);
        check("rate_words", 64'(n_emit), 64'd101);
        check("rate_bad_gaps", 64'(gap_bad), 64'd0);
        check("rate_sb_drained", 64'(sb.size()), 64'd0);

        // AFULL held for 20 cycles mid-payload.
        push_run(4'h1, 40, 40, 0, 0);
        n_emit = 0;
        start_run(4'h1, 40, 40, 255);
        wait_emit("afull", 12, 200);
        afull = 1'b1;
        viol  = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (tx_b != 4'd0) viol++;
        end
        afull = 1'b0;
        check("afull_quiet", 64'(viol), 64'd0);
        wait_idle("afull", 300);
        check("afull_words", 64'(n_emit), 64'd41);
        check("afull_sb_drained", 64'(sb.size()), 64'd0);

        // INS_ERROR high across ARB and HDR: header clean, first payload word flipped once.
        push_run(4'h1, 8, 4, 1, 0);
        n_emit = 0;
        start_run(4'h1, 8, 4, 255);
        tick();
        ins_err = 1'b1;
        tick();
        tick();
        ins_err = 1'b0;
        wait_idle("err", 200);
        check("err_words", 64'(n_emit), 64'd10);
        check("err_sb_drained", 64'(sb.size()), 64'd0);

        // DATA_GEN falls mid-block: current block completes, no DONE.
        push_run(4'h1, 20, 8, 0, 1);
        n_emit = 0;
        d0     = done_cnt;
        start_run(4'h1, 20, 8, 255);
        wait_emit("stop", 3, 100);
        dgen = 1'b0;
        wait_idle("stop", 200);
        check("stop_words", 64'(n_emit), 64'd9);
        check("stop_no_done", 64'(done_cnt - d0), 64'd0);
        check("stop_ch_done", 64'(ch_done), 64'hE);
        check("stop_sb_drained", 64'(sb.size()), 64'd0);

        // ESTABLISHED drops mid-block, then a fresh run restarts counters at 0.
        push_run(4'h1, 40, 40, 0, 0);
        n_emit = 0;
        d0     = done_cnt;
        start_run(4'h1, 40, 40, 255);
        wait_emit("est", 6, 100);
        est = 1'b0;
        tick();
        @(negedge clk);
        check("est_busy_fell", 64'(busy), 64'd0);
        check("est_tx_b", 64'(tx_b), 64'd0);
        tick();
        tick();
        check("est_no_done", 64'(done_cnt - d0), 64'd0);
        sb.delete();
        est = 1'b1;
        push_run(4'h1, 6, 4, 0, 0);
        n_emit = 0;
        d0     = done_cnt;
        start_run(4'h1, 6, 4, 255);
        wait_idle("restart", 200);
        check("restart_words", 64'(n_emit), 64'd8);
        check("restart_done", 64'(done_cnt - d0), 64'd1);
        check("restart_sb_drained", 64'(sb.size()), 64'd0);

        // Zero words: DONE two cycles after the DATA_GEN rise, nothing emitted.
        n_emit = 0;
        start_run(4'b0101, 0, 4, 255);
        tick();
        @(negedge clk);
        check("zero_done_early", 64'(done), 64'd0);
        check("zero_busy", 64'(busy), 64'd1);
        tick();
        @(negedge clk);
        check("zero_done_pulse", 64'(done), 64'd1);
        check("zero_busy_fell", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        check("zero_done_single", 64'(done), 64'd0);
        check("zero_ch_done", 64'(ch_done), 64'hF);
        check("zero_words", 64'(n_emit), 64'd0);

        // Reset mid-run returns to reset values and the RR pointer restarts at channel 0.
        push_run(4'hF, 10, 4, 0, 0);
        n_emit = 0;
        start_run(4'hF, 10, 4, 255);
        wait_emit("mrst", 5, 100);
        rst_n = 1'b0;
        dgen  = 1'b0;
        tick();
        @(negedge clk);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_tx_b", 64'(tx_b), 64'd0);
        check("mrst_tx_d", tx_d, 64'd0);
        check("mrst_ch_done", 64'(ch_done), 64'd0);
        sb.delete();
        m_rr = NCH - 1;
        tick();
        rst_n = 1'b1;
        tick();
        push_run(4'hF, 2, 4, 0, 0);
        n_emit = 0;
        start_run(4'hF, 2, 4, 255);
        wait_idle("mrst", 200);
        check("mrst_words", 64'(n_emit), 64'd12);
        check("mrst_sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tcp_test_gen_mc.md
Name: tcp_test_gen_mc

Overview:
Multi-channel successor to the single-stream TCP test generator. It runs NCH independent counter-pattern sources and merges them into blocks on the SiTCPXG TX interface, with round-robin arbitration and framed headers. A fractional rate throttle, AFULL backpressure and one-shot error insertion are included. It sits between the test control registers and the SiTCPXG core, in the CLK156M domain.

Parameters:
NCH, 4, number of pattern channels (1..16)
CNT_W, 32, width of per-channel word-count budget
BLK_W, 16, width of block-length field

Ports:
CLK156M  in  1  system clock, 156.25 MHz
RSTs_N  in  1  synchronous reset, active-low
SiTCPXG_ESTABLISHED  in  1  TCP session open
DATA_GEN  in  1  run request; rising edge starts a run
CH_ENB  in  NCH  per-channel enable, latched at start
TX_RATE  in  8  throttle; word credit rate = (TX_RATE+1)/256 per cycle
NUM_OF_WORDS  in  CNT_W  payload words per channel per run
BLK_WORDS  in  BLK_W  payload words per block
INS_ERROR  in  1  pulse; corrupts next payload word
SiTCPXG_TX_AFULL  in  1  TX FIFO almost full
SiTCPXG_TX_D  out  64  TX data
SiTCPXG_TX_B  out  4  valid byte count (8 = full word, 0 = no data)
BUSY  out  1  run in progress
DONE  out  1  one-cycle pulse at normal run completion
CH_DONE  out  NCH  channel budget exhausted (sticky until next start)

Behaviour:
- Reset values (RSTs_N=0 on a clock edge): all outputs 0, FSM in IDLE, accumulator 0, token 0, error-pending 0, RR pointer = NCH-1.
- Start condition: DATA_GEN rising edge AND ESTABLISHED AND state==IDLE.
- On start: latch CH_ENB, NUM_OF_WORDS and max(BLK_WORDS,1); clear per-channel remaining/seq/word counters, CH_DONE and error-pending.
- CH_DONE is set at start for every disabled channel.
- Throttle: 9-bit sum = acc + TX_RATE + 1. acc <= sum[7:0] every cycle while BUSY. sum[8] sets token.
- Token is a single bit, so it saturates. It is cleared when a word is emitted.
- Emit condition: token AND !SiTCPXG_TX_AFULL AND state in {HDR, PAY}.
- TX_D/TX_B are registered: an emit decision in cycle n appears on the outputs in cycle n+1. Non-emit cycles drive TX_B=0; TX_D holds its last value.
- FSM IDLE -> ARB: on start.
- FSM ARB (1 cycle): grant the first channel after the RR pointer (wrapping) with remaining>0. If one is found, update the pointer and go to HDR. If none remain, pulse DONE and go to IDLE.
- FSM HDR: emit one header word {8'hA5, 8'(ch), 16'(blk_seq[ch]), 32'(len)}, where len = min(remaining[ch], BLK_WORDS). Then go to PAY.
- FSM PAY: emit len payload words {8'(ch), 56'(word_cnt[ch])}; word_cnt[ch] increments per word.
- End of PAY: remaining[ch] -= len and blk_seq[ch]++ (16-bit wrap). Set CH_DONE[ch] if remaining hits 0. Go to ARB.
- word_cnt wraps at 2^56. Block lengths are never split across arbitration.
- INS_ERROR sets error-pending. The next emitted payload word has bit 0 inverted, then pending clears. Header words are never corrupted. A second pulse while pending has no extra effect.
- DATA_GEN falling mid-run: finish the current block, then go to IDLE without a DONE pulse.
- ESTABLISHED falling: go to IDLE on the next cycle with TX_B=0. The partial block is abandoned, no DONE pulse.
- NUM_OF_WORDS=0 or CH_ENB all zero: ARB finds no channel. DONE pulses 2 cycles after start and no words are emitted.
- BUSY = (state != IDLE).
- RSTs_N low mid-run: immediate return to reset values on that edge.

Test Plan:
- NCH=4, CH_ENB=4'hF, NUM_OF_WORDS=10, BLK_WORDS=4, TX_RATE=255 -> blocks emitted in order ch0,1,2,3 (len 4), ch0..3 (len 4), ch0..3 (len 2). That is 52 words, with blk_seq 0,1,2 per channel, then one DONE pulse and CH_DONE=4'hF.
- TX_RATE=63, single channel, 100 words -> TX_B nonzero on exactly 1 in 4 cycles over a long window; payload counter contiguous 0..99.
- AFULL held high for 20 cycles mid-PAY -> no TX_B≠0 during those cycles; the stream resumes with no gap or duplicate in word_cnt.
- INS_ERROR pulse during a header cycle -> header intact; the first following payload word has bit 0 flipped; the next word is correct.
- ESTABLISHED dropped mid-block -> BUSY falls within 1 cycle, no DONE. A restart via DATA_GEN edge resets counters to 0.
- CH_ENB=4'b0101, NUM_OF_WORDS=0 -> DONE pulse 2 cycles after start, zero words, CH_DONE=4'hF.
